fft_bitrev_reorder: RTL and testbench

//  Output unscrambler for the radix-2 pipelined FFT. The butterfly chain emits X[k] in bit-reversed order.

---
 rtl/fft_pkg.sv | 29 ++
 rtl/fft_bitrev_reorder_if.sv | 32 +++
 rtl/fft_pingpong_ram.sv | 37 +++
 rtl/fft_bitrev_reorder.sv | 143 ++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : fft_pkg                                                         |
// | Purpose  : Shared defaults and helpers for the radix-2 pipelined FFT.      |
// |            FFT_LOG2N / FFT_N / FFT_DATA_W : default sizing                 |
// |            sample_t : packed {real | imag} sample, signed halves           |
// |            bitrev() : index bit reversal at the default size               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package fft_pkg;

    localparam int FFT_LOG2N  = 3;
    localparam int FFT_N      = 1 << FFT_LOG2N;
    localparam int FFT_DATA_W = 16;

    typedef logic [FFT_DATA_W-1:0] sample_t;

    // Pure wiring: bit i of the result is bit (LOG2N-1-i) of the index.
    function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] k);
        logic [FFT_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < FFT_LOG2N; i++) begin
            r[i] = k[FFT_LOG2N-1-i];
        end
        return r;
    endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_bitrev_reorder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : fft_bitrev_reorder_if                                          |
// | Purpose   : Valid/ready streams around the bit-reversal unscrambler.       |
// |             in_valid/in_ready/in_data        : bit-reversed input stream   |
// |             out_valid/out_ready/out_data/out_last : natural-order output   |
// |             modport slave  : the reorder block                             |
// |             modport master : the environment (producer + consumer)         |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface fft_bitrev_reorder_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface : fft_bitrev_reorder_if
`default_nettype wire

// File: rtl/fft_pingpong_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_pingpong_ram                                                |
// | Purpose  : Two banks of N x DATA_W storage for frame double-buffering.     |
// |            clk   : write clock                                             |
// |            we    : write enable; wbank/waddr/wdata select and supply data  |
// |            rbank/raddr : asynchronous read address, rdata : read data      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fft_pingpong_ram #(
    parameter int LOG2N  = 3,
    parameter int DATA_W = 16
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic              wbank,
    input  wire logic [LOG2N-1:0]  waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic              rbank,
    input  wire logic [LOG2N-1:0]  raddr,
    output      logic [DATA_W-1:0] rdata
);
    localparam int c_depth = 2 << LOG2N;

    // Bank select is the MSB of the flat address.
    logic [DATA_W-1:0] r_mem [c_depth];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[{wbank, waddr}] <= wdata;
        end
    end

    assign rdata = r_mem[{rbank, raddr}];

endmodule : fft_pingpong_ram
`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_bitrev_reorder                                              |
// | Purpose  : Output unscrambler for the radix-2 pipelined FFT. Frames arrive |
// |            in bit-reversed order, are buffered in a ping-pong store and    |
// |            replayed in natural order X[0]..X[N-1].                         |
// |            clk   : rising-edge clock                                       |
// |            rst_n : asynchronous active-low reset                           |
// |            bus   : fft_bitrev_reorder_if.slave                             |
// |                    in_valid/in_ready/in_data  - bit-reversed input         |
// |                    out_valid/out_ready/out_data/out_last - natural output  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int LOG2N  = FFT_LOG2N,
    parameter int DATA_W = FFT_DATA_W
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fft_bitrev_reorder_if.slave bus
);
    localparam logic [LOG2N-1:0] c_last = {LOG2N{1'b1}};

    logic              r_rst_done;
    logic [LOG2N-1:0]  r_wr_cnt;
    logic [LOG2N-1:0]  r_rd_cnt;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [1:0]        r_full;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;

    logic [LOG2N-1:0]  w_wr_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_wr_wrap;
    logic              w_load;
    logic              w_rd_wrap;
    logic [1:0]        w_set;
    logic [1:0]        w_clr;

    // Write address is the bit-reversed arrival index, so sample k lands in
    // slot bitrev(k) and the reader can walk the bank linearly.
    for (genvar i = 0; i < LOG2N; i++) begin : g_bitrev
        assign w_wr_addr[i] = r_wr_cnt[LOG2N-1-i];
    end

    // in_ready stays low until the first clock after reset release.
    assign w_in_ready = r_rst_done && !r_full[r_wr_bank];
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_wr_wrap  = w_in_fire && (r_wr_cnt == c_last);

    assign w_load     = (!r_out_valid || bus.out_ready) && r_full[r_rd_bank];
    assign w_rd_wrap  = w_load && (r_rd_cnt == c_last);

    // Writer only sets a bank that is empty and the reader only clears a bank
    // that is full, so set and clear never target the same bank.
    assign w_set = w_wr_wrap ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr = w_rd_wrap ? (2'b01 << r_rd_bank) : 2'b00;

    fft_pingpong_ram #(
        .LOG2N  (LOG2N),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_in_fire),
        .wbank (r_wr_bank),
        .waddr (w_wr_addr),
        .wdata (bus.in_data),
        .rbank (r_rd_bank),
        .raddr (r_rd_cnt),
        .rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    // Write side: counter and bank pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
        end else if (w_in_fire) begin
            r_wr_cnt <= r_wr_cnt + LOG2N'(1);
            if (w_wr_wrap) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full | w_set) & ~w_clr;
        end
    end

    // Read side: counter and bank pointer advance on each output load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt  <= '0;
            r_rd_bank <= 1'b0;
        end else if (w_load) begin
            r_rd_cnt <= r_rd_cnt + LOG2N'(1);
            if (w_rd_wrap) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Output register: holds data/last while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_rd_data;
            r_out_last  <= (r_rd_cnt == c_last);
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;

endmodule : fft_bitrev_reorder
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fft_bitrev_reorder                                           |
// | Purpose  : Scoreboard bench for fft_bitrev_reorder (N=8, DATA_W=16).       |
// |            Stimulus pushes natural-order expectations; a negedge monitor   |
// |            pops and compares on every output handshake.                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fft_bitrev_reorder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fft_bitrev_reorder_if #(.DATA_W(16)) bus ();

    fft_bitrev_reorder #(
        .LOG2N  (3),
        .DATA_W (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int notready_cnt = 0;

    // {last, data}
    logic [16:0] exp_q[$];

    // Bit-reversed arrival order for N=8, worked by hand.
    int pos_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int pat_tab[4] = '{1, 0, 0, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    always @(negedge clk) begin
        logic [16:0] e;
        if (prev_stall && rst_n) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data",  32'(bus.out_data),  32'(prev_data));
            check("hold_last",  32'(bus.out_last),  32'(prev_last));
        end
        prev_stall = rst_n && bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0h required=none", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e[15:0]));
                check("out_last", 32'(bus.out_last), 32'(e[16]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [15:0] d);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        if (!bus.in_ready) notready_cnt++;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_ready required=ready");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic push_frame(input int tag);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({(i == 7), 16'(tag * 16 + i)});
        end
    endtask

    task automatic send_frame(input int tag, input int count);
        for (int k = 0; k < count; k++) begin
            send(16'(tag * 16 + pos_tab[k]));
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int bubbles;
        int t;
        logic done;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_before_clk", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready_after_clk", 32'(bus.in_ready), 32'd1);

        // Test 1: single frame 0,4,2,6,1,5,3,7
        push_frame(0);
        send_frame(0, 8);
        idle();
        check("t1_valid_at_accept", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("t1_first_valid", 32'(bus.out_valid), 32'd1);
        check("t1_first_data",  32'(bus.out_data),  32'h0000);
        wait_drain();

        // Test 2: three frames back-to-back, no bubbles, in_ready held high
        notready_cnt = 0;
        push_frame(1);
        push_frame(2);
        push_frame(3);
        bubbles = 0;
        fork
            begin
                send_frame(1, 8);
                send_frame(2, 8);
                send_frame(3, 8);
                idle();
            end
            begin
                t = 0;
                @(negedge clk);
                while (!bus.out_valid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                for (int i = 0; i < 24; i++) begin
                    if (!bus.out_valid) bubbles++;
                    @(negedge clk);
                end
            end
        join
        check("t2_bubbles", 32'(bubbles), 32'd0);
        check("t2_in_ready_drops", 32'(notready_cnt), 32'd0);
        wait_drain();

        // Test 3: consumer stalled, both banks fill
        bus.out_ready = 1'b0;
        push_frame(0);
        push_frame(5);
        push_frame(6);
        send_frame(0, 8);
        send_frame(5, 8);
        check("t3_in_ready_full", 32'(bus.in_ready),  32'd0);
        check("t3_out_valid",     32'(bus.out_valid), 32'd1);
        check("t3_out_data",      32'(bus.out_data),  32'h0000);
        repeat (5) @(negedge clk);
        check("t3_out_data_held", 32'(bus.out_data),  32'h0000);
        @(posedge clk);
        #1;
        fork
            begin
                send_frame(6, 8);
                idle();
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        check("t3_in_ready_after", 32'(bus.in_ready), 32'd1);

        // Test 4: out_ready pattern 1,0,0,1
        push_frame(7);
        push_frame(8);
        done = 1'b0;
        fork
            begin
                send_frame(7, 8);
                send_frame(8, 8);
                idle();
                wait_drain();
                done = 1'b1;
            end
            begin
                int pi;
                pi = 0;
                while (!done) begin
                    bus.out_ready = pat_tab[pi % 4][0];
                    pi++;
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Test 5: reset mid-frame while previous frame is being output
        push_frame(9);
        send_frame(9, 8);
        send_frame(10, 5);
        rst_n = 1'b0;
        exp_q.delete();
        idle();
        #1;
        check("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_out_data",  32'(bus.out_data),  32'd0);
        check("t5_rst_out_last",  32'(bus.out_last),  32'd0);
        check("t5_rst_in_ready",  32'(bus.in_ready),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("t5_in_ready_before_clk", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("t5_in_ready_after_clk", 32'(bus.in_ready), 32'd1);
        push_frame(11);
        send_frame(11, 8);
        idle();
        wait_drain();

        // Test 6: input valid every third clock
        push_frame(12);
        for (int k = 0; k < 8; k++) begin
            send(16'(12 * 16 + pos_tab[k]));
            idle();
            if (k != 7) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
        check("t6_valid_at_accept", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("t6_first_valid", 32'(bus.out_valid), 32'd1);
        check("t6_first_data",  32'(bus.out_data),  32'h00C0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fft_bitrev_reorder
`default_nettype wire
